// File: rtl/pqvalue_pkg.sv
// pqvalue_pkg: shared types and constants for the PQ modular ALU.
//   - pq_op_e    : operation select encoding (sel_op_i)
//   - pq_red_e   : modulus select encoding (sel_red_i)
//   - pq_state_e : control FSM states
//   - default width, moduli and Kyber iteration count
package pqvalue_pkg;

    localparam int unsigned PQ_WIDTH    = 23;
    localparam logic [22:0] PQ_Q_DIL    = 23'd8380417;
    localparam logic [22:0] PQ_Q_KYB    = 23'd3329;
    localparam int unsigned PQ_KYB_BITS = 12;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_MUL  = 2'b11
    } pq_op_e;

    typedef enum logic {
        RED_DIL = 1'b0,
        RED_KYB = 1'b1
    } pq_red_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } pq_state_e;

endpackage

// File: rtl/pqvalue_mul_iter.sv
// pqvalue_mul_iter: bit-serial interleaved modular multiplier.
// Scans b MSB-first, one bit per cycle: acc = 2*acc mod q, then acc += a mod q
// when the bit is set. Operands and modulus are latched on start.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start         : load operands, clear acc, begin iterating next cycle
//   kyb           : 1 = scan KYB_BITS bits of b, 0 = scan WIDTH bits
//   a, b, q       : operands and modulus sampled on start
//   acc_next      : value acc takes at the end of the current step
//   done          : the current cycle performs the step on bit 0
module pqvalue_mul_iter
    import pqvalue_pkg::*;
#(
    parameter int unsigned WIDTH    = PQ_WIDTH,
    parameter int unsigned KYB_BITS = PQ_KYB_BITS
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start,
    input  logic             kyb,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] acc_next,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;

    logic [WIDTH:0]   dbl_s;
    logic [WIDTH:0]   dbl_red_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   sum_red_s;

    // One multiply step: double-and-reduce, then conditional add-and-reduce.
    // WIDTH+1 bits hold 2*acc and acc+a without overflow for in-range operands.
    always_comb begin
        dbl_s = {acc_r, 1'b0};
        if (dbl_s >= {1'b0, q_r}) begin
            dbl_red_s = dbl_s - {1'b0, q_r};
        end else begin
            dbl_red_s = dbl_s;
        end
        if (b_r[cnt_r]) begin
            sum_s = dbl_red_s + {1'b0, a_r};
        end else begin
            sum_s = dbl_red_s;
        end
        if (sum_s >= {1'b0, q_r}) begin
            sum_red_s = sum_s - {1'b0, q_r};
        end else begin
            sum_red_s = sum_s;
        end
    end

    assign acc_next = sum_red_s[WIDTH-1:0];
    assign done     = busy_r && (cnt_r == {CNT_W{1'b0}});

    // Operand capture, accumulator and bit counter.
    // The counter always reaches zero, so busy_r clears even for out-of-range operands.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            q_r    <= {WIDTH{1'b0}};
            acc_r  <= {WIDTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b0;
        end else if (start) begin
            a_r    <= a;
            b_r    <= b;
            q_r    <= q;
            acc_r  <= {WIDTH{1'b0}};
            cnt_r  <= kyb ? CNT_W'(KYB_BITS - 1) : CNT_W'(WIDTH - 1);
            busy_r <= 1'b1;
        end else if (busy_r) begin
            acc_r <= acc_next;
            if (cnt_r == {CNT_W{1'b0}}) begin
                busy_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
        end else begin
            acc_r  <= acc_r;
            busy_r <= 1'b0;
        end
    end

endmodule

// File: rtl/pqvalue_seq.sv
// pqvalue_seq: sequential modular ALU (add/sub/mul mod Dilithium or Kyber q)
// behind a valid/ready handshake. One operation in flight at most.
// Ports:
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   in_valid_i / in_ready_o : request handshake (ready only in IDLE)
//   a_i, b_i                : operands (< selected q), sampled at acceptance
//   sel_op_i                : 00 none (result 0), 01 add, 10 sub, 11 mul
//   sel_red_i               : 0 Dilithium, 1 Kyber
//   out_valid_o/out_ready_i : result handshake; result_o held while waiting
//   result_o                : result (< selected q)
// Latency from acceptance: 1 cycle for add/sub/none, 1+n for mul
// (n = KYB_BITS in Kyber mode, WIDTH in Dilithium mode).
module pqvalue_seq
    import pqvalue_pkg::*;
#(
    parameter int unsigned      WIDTH    = PQ_WIDTH,
    parameter logic [WIDTH-1:0] Q_DIL    = PQ_Q_DIL,
    parameter logic [WIDTH-1:0] Q_KYB    = PQ_Q_KYB,
    parameter int unsigned      KYB_BITS = PQ_KYB_BITS
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       sel_op_i,
    input  logic             sel_red_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o
);

    pq_state_e        state_r;
    pq_state_e        state_next_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;

    logic             load_res_s;
    logic [WIDTH-1:0] res_next_s;
    logic             mul_start_s;
    logic [WIDTH-1:0] mul_acc_next_s;
    logic             mul_done_s;

    logic [WIDTH-1:0] q_sel_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] add_res_s;
    logic [WIDTH-1:0] sub_res_s;

    assign q_sel_s = (pq_red_e'(sel_red_i) == RED_KYB) ? Q_KYB : Q_DIL;

    // Single-cycle add/sub on the live inputs; only used on the accepting cycle.
    // For a < b the wrapped difference plus q lands back in [0, q) after truncation.
    always_comb begin
        sum_s  = {1'b0, a_i} + {1'b0, b_i};
        diff_s = {1'b0, a_i} - {1'b0, b_i};
        if (sum_s >= {1'b0, q_sel_s}) begin
            add_res_s = WIDTH'(sum_s - {1'b0, q_sel_s});
        end else begin
            add_res_s = sum_s[WIDTH-1:0];
        end
        if (a_i < b_i) begin
            sub_res_s = WIDTH'(diff_s + {1'b0, q_sel_s});
        end else begin
            sub_res_s = diff_s[WIDTH-1:0];
        end
    end

    // Next-state, result-load and multiplier-start decode.
    always_comb begin
        state_next_s = state_r;
        load_res_s   = 1'b0;
        res_next_s   = {WIDTH{1'b0}};
        mul_start_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid_i) begin
                    case (pq_op_e'(sel_op_i))
                        OP_ADD: begin
                            load_res_s   = 1'b1;
                            res_next_s   = add_res_s;
                            state_next_s = DONE;
                        end
                        OP_SUB: begin
                            load_res_s   = 1'b1;
                            res_next_s   = sub_res_s;
                            state_next_s = DONE;
                        end
                        OP_MUL: begin
                            mul_start_s  = 1'b1;
                            state_next_s = MUL;
                        end
                        default: begin
                            load_res_s   = 1'b1;
                            res_next_s   = {WIDTH{1'b0}};
                            state_next_s = DONE;
                        end
                    endcase
                end else begin
                    state_next_s = IDLE;
                end
            end
            MUL: begin
                if (mul_done_s) begin
                    load_res_s   = 1'b1;
                    res_next_s   = mul_acc_next_s;
                    state_next_s = DONE;
                end else begin
                    state_next_s = MUL;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, handshake flags and result register.
    // Flags are registered from the next state so both outputs come straight from flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
            if (load_res_s) begin
                result_r <= res_next_s;
            end else begin
                result_r <= result_r;
            end
        end
    end

    pqvalue_mul_iter #(
        .WIDTH    (WIDTH),
        .KYB_BITS (KYB_BITS)
    ) u_mul_iter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start    (mul_start_s),
        .kyb      (sel_red_i),
        .a        (a_i),
        .b        (b_i),
        .q        (q_sel_s),
        .acc_next (mul_acc_next_s),
        .done     (mul_done_s)
    );

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign result_o    = result_r;

endmodule

// File: tb/tb_pqvalue_seq.sv
// Self-checking bench for pqvalue_seq: vector table, randomized multiplies
// against a wide-multiply reference, backpressure and mid-multiply reset.
module tb_pqvalue_seq;

    logic        clk;
    logic        rst_ni;
    logic        in_valid;
    logic        in_ready;
    logic [22:0] a_in;
    logic [22:0] b_in;
    logic [1:0]  sel_op;
    logic        sel_red;
    logic        out_valid;
    logic        out_ready;
    logic [22:0] result;

    int tests;
    int fails;
    logic [22:0] sb_q[$];

    pqvalue_seq dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a_in),
        .b_i         (b_in),
        .sel_op_i    (sel_op),
        .sel_red_i   (sel_red),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        red;
        logic [22:0] a;
        logic [22:0] b;
        logic [22:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one request, wait (bounded) for the result, check latency/busy/result.
    task automatic run_op(input logic [1:0] op, input logic red, input logic [22:0] a,
                          input logic [22:0] b, input logic [22:0] exp, input int lat,
                          input string name);
        int   cyc;
        logic busy_ok;
        logic [22:0] want;
        @(posedge clk); #1;
        sel_op   = op;
        sel_red  = red;
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        sb_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        sel_red  = ~red;
        a_in     = 23'($urandom);
        b_in     = 23'($urandom);
        sel_op   = 2'($urandom);
        cyc      = 1;
        busy_ok  = 1'b1;
        while (!out_valid && cyc <= 40) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_latency"}, cyc, lat);
        check({name, "_busy"}, {31'd0, busy_ok & ~in_ready}, 32'd1);
        want = sb_q.pop_front();
        check({name, "_result"}, {9'd0, result}, {9'd0, want});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [22:0] q;
        logic [22:0] ra;
        logic [22:0] rb;
        longint      prod;
        logic        seen;

        tests = 0;
        fails = 0;

        vecs[0]  = '{2'b01, 1'b0, 23'd8380416, 23'd1,       23'd0,       1};
        vecs[1]  = '{2'b01, 1'b0, 23'd5,       23'd7,       23'd12,      1};
        vecs[2]  = '{2'b10, 1'b1, 23'd0,       23'd1,       23'd3328,    1};
        vecs[3]  = '{2'b10, 1'b1, 23'd100,     23'd30,      23'd70,      1};
        vecs[4]  = '{2'b11, 1'b1, 23'd3328,    23'd3328,    23'd1,       13};
        vecs[5]  = '{2'b11, 1'b0, 23'd2,       23'd4190209, 23'd1,       24};
        vecs[6]  = '{2'b11, 1'b0, 23'd8380416, 23'd8380416, 23'd1,       24};
        vecs[7]  = '{2'b00, 1'b0, 23'd1234,    23'd5678,    23'd0,       1};
        vecs[8]  = '{2'b01, 1'b1, 23'd3000,    23'd1000,    23'd671,     1};
        vecs[9]  = '{2'b11, 1'b1, 23'd17,      23'd200,     23'd71,      13};
        vecs[10] = '{2'b10, 1'b0, 23'd5,       23'd7,       23'd8380415, 1};
        vecs[11] = '{2'b11, 1'b0, 23'd3,       23'd5,       23'd15,      24};
        vecs[12] = '{2'b01, 1'b1, 23'd3328,    23'd0,       23'd3328,    1};

        rst_ni    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_in      = 23'd0;
        b_in      = 23'd0;
        sel_op    = 2'b00;
        sel_red   = 1'b0;
        #12;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", {9'd0, result}, 32'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].red, vecs[i].a, vecs[i].b, vecs[i].exp,
                   vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Random multiplies against a wide-multiply reference.
        for (int i = 0; i < 6; i++) begin
            q    = i[0] ? 23'd3329 : 23'd8380417;
            ra   = 23'($urandom_range(int'(q) - 1, 0));
            rb   = 23'($urandom_range(int'(q) - 1, 0));
            prod = (longint'(ra) * longint'(rb)) % longint'(q);
            run_op(2'b11, i[0], ra, rb, 23'(prod), i[0] ? 13 : 24,
                   $sformatf("rmul%0d", i));
        end

        // Backpressure: result held for 10 cycles, new requests ignored.
        @(posedge clk); #1;
        out_ready = 1'b0;
        sel_op    = 2'b01;
        sel_red   = 1'b1;
        a_in      = 23'd3000;
        b_in      = 23'd1000;
        in_valid  = 1'b1;
        sb_q.push_back(23'd671);
        @(posedge clk); #1;
        check("bp_valid_t1", {31'd0, out_valid}, 32'd1);
        ra = sb_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            sel_op   = 2'b10;
            a_in     = 23'd1;
            b_in     = 23'd2;
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_result", {9'd0, result}, {9'd0, ra});
            check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_still_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("bp_no_phantom", {31'd0, out_valid}, 32'd0);

        // Reset pulse in the middle of a Dilithium multiply.
        sel_op   = 2'b11;
        sel_red  = 1'b0;
        a_in     = 23'd2;
        b_in     = 23'd4190209;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_ni = 1'b0;
        #1;
        check("rst_async_ready", {31'd0, in_ready}, 32'd1);
        check("rst_async_valid", {31'd0, out_valid}, 32'd0);
        check("rst_async_result", {9'd0, result}, 32'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("rst_no_stale_valid", {31'd0, seen}, 32'd0);
        run_op(2'b01, 1'b0, 23'd5, 23'd7, 23'd12, 1, "post_rst_add");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
